// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode/funct
// fields, ALU operation codes and datapath mux selects.
package mips_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC     = 4'd2,
        ST_R_WB     = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WB   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_ADDI_EX  = 4'd9,
        ST_ADDI_WB  = 4'd10,
        ST_JUMP     = 4'd11,
        ST_ERR      = 4'd12
    } state_e;

    typedef enum logic [1:0] {
        ALU_MODE_ADD   = 2'd0,
        ALU_MODE_SUB   = 2'd1,
        ALU_MODE_FUNCT = 2'd2
    } alu_mode_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational ALU-control decode: the FSM picks add, sub or "follow funct";
// funct_valid flags whether an R-type funct is one we implement.
module mips_alu_decode
    import mips_pkg::*;
#(
    parameter int FUNCT_W   = 6,
    parameter int ALUCTRL_W = 3
) (
    input  alu_mode_e            alu_mode,
    input  logic [FUNCT_W-1:0]   funct,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic                 funct_valid
);

    always_comb begin
        alu_ctrl    = ALUCTRL_W'(ALU_ADD);
        funct_valid = 1'b0;
        case (alu_mode)
            ALU_MODE_SUB: alu_ctrl = ALUCTRL_W'(ALU_SUB);
            ALU_MODE_FUNCT: begin
                funct_valid = 1'b1;
                case (funct)
                    FN_ADD:  alu_ctrl = ALUCTRL_W'(ALU_ADD);
                    FN_SUB:  alu_ctrl = ALUCTRL_W'(ALU_SUB);
                    FN_AND:  alu_ctrl = ALUCTRL_W'(ALU_AND);
                    FN_OR:   alu_ctrl = ALUCTRL_W'(ALU_OR);
                    FN_SLT:  alu_ctrl = ALUCTRL_W'(ALU_SLT);
                    default: funct_valid = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready, and latches sticky illegal-opcode and memory-timeout flags.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int FUNCT_W     = 6,
    parameter int ALUCTRL_W   = 3,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           pc_source,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic [3:0]           state_o,
    output logic                 illegal_op,
    output logic                 timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    state_e           state, state_next;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
    logic             illegal_next, timeout_next;
    logic             in_wait, wait_expired;
    logic             funct_valid;
    alu_mode_e        alu_mode;

    // Memory handshake: mem_read/mem_write stay high in their state until the
    // cycle mem_ready=1 is sampled; that cycle completes the transfer and advances.
    assign in_wait      = state inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR};
    assign wait_expired = in_wait && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign state_o      = state;

    mips_alu_decode #(
        .FUNCT_W   (FUNCT_W),
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_decode (
        .alu_mode    (alu_mode),
        .funct       (funct),
        .alu_ctrl    (alu_ctrl),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FETCH;
            wait_cnt   <= '0;
            illegal_op <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_next;
            wait_cnt   <= wait_cnt_next;
            illegal_op <= illegal_next;
            timeout    <= timeout_next;
        end
    end

    always_comb begin
        state_next    = state;
        illegal_next  = illegal_op;
        timeout_next  = timeout;
        wait_cnt_next = (in_wait && !mem_ready && !wait_expired) ? wait_cnt + 1'b1 : '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        pc_source     = PCSRC_ALU;
        alu_mode      = ALU_MODE_ADD;

        case (state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_RTYPE:     state_next = ST_EXEC;
                    OP_LW, OP_SW: state_next = ST_MEM_ADDR;
                    OP_BEQ:       state_next = ST_BRANCH;
                    OP_ADDI:      state_next = ST_ADDI_EX;
                    OP_J:         state_next = ST_JUMP;
                    default: begin
                        state_next   = ST_ERR;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                alu_mode  = ALU_MODE_FUNCT;
                if (funct_valid) begin
                    state_next = ST_R_WB;
                end else begin
                    state_next   = ST_ERR;
                    illegal_next = 1'b1;
                end
            end
            ST_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                state_next = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_next = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_next = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_mode      = ALU_MODE_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                state_next    = ST_FETCH;
            end
            ST_ADDI_EX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                state_next = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                reg_write  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                state_next = ST_FETCH;
            end
            default: ;
        endcase

        // Timeout only fires when mem_ready is low, so a late ready still advances normally.
        if (wait_expired) begin
            state_next   = ST_ERR;
            timeout_next = 1'b1;
        end

        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = SRCB_RT;
            pc_source     = PCSRC_ALU;
            alu_mode      = ALU_MODE_ADD;
        end
    end

endmodule
